change_dispenser: RTL and testbench

//  Coin-payout end of the vending machine's change/return interface. Accepts a

---
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//   Coin-payout end of the change/return interface. Accepts a payout request
//   in value-1 units and pays it greedily (value-2 coins first, then value-1
//   coins), issuing one eject pulse per coin. It tracks the stock of both
//   hoppers and reports any unpaid remainder when the stock runs out.
//
//   Optional feature macro: DISPENSE_ABORT_EN adds the 'abort' input.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_amt           amount to pay out
//   load_stock        overwrite both stock counters from load1/load2 (idle only)
//   eject1, eject2    hopper eject pulses (never both high)
//   busy              high from the cycle after accept through the done cycle
//   done              1-cycle completion strobe
//   short, owed       unpaid flag / remainder; valid with done, held until next accept
//   stock1, stock2    current hopper stock
//   abort             (DISPENSE_ABORT_EN only) stop at next SELECT/GAP decision
module change_dispenser #(
  parameter int unsigned AMT_W       = 3,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned GAP_CYC     = 1,
  parameter int unsigned STOCK1_INIT = 8,
  parameter int unsigned STOCK2_INIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amt,
  output logic               req_ready,
  input  logic               load_stock,
  input  logic [STOCK_W-1:0] load1,
  input  logic [STOCK_W-1:0] load2,
  output logic               eject1,
  output logic               eject2,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   owed,
  output logic [STOCK_W-1:0] stock1,
  output logic [STOCK_W-1:0] stock2
`ifdef DISPENSE_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [AMT_W-1:0]   owed_q, owed_d;
  logic               short_q, short_d;
  logic [STOCK_W-1:0] stock1_q, stock1_d;
  logic [STOCK_W-1:0] stock2_q, stock2_d;
  logic               coin2_q, coin2_d;   // coin being ejected is value-2
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // shared EJECT/GAP cycle counter
  logic               abort_w;

`ifdef DISPENSE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    owed_d      = owed_q;
    short_d     = short_q;
    stock1_d    = stock1_q;
    stock2_d    = stock2_q;
    coin2_d     = coin2_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (load_stock) begin
          stock1_d = load1;
          stock2_d = load2;
        end
        if (req_valid) begin
          remaining_d = req_amt;
          owed_d      = '0;
          short_d     = 1'b0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        if (abort_w) begin
          owed_d  = remaining_q;
          short_d = (remaining_q != '0);
          state_d = S_DONE;
        end else if ((remaining_q >= AMT_W'(2)) && (stock2_q != '0)) begin
          coin2_d     = 1'b1;
          stock2_d    = stock2_q - STOCK_W'(1);
          remaining_d = remaining_q - AMT_W'(2);
          state_d     = S_EJECT;
        end else if ((remaining_q != '0) && (stock1_q != '0)) begin
          coin2_d     = 1'b0;
          stock1_d    = stock1_q - STOCK_W'(1);
          remaining_d = remaining_q - AMT_W'(1);
          state_d     = S_EJECT;
        end else begin
          owed_d  = remaining_q;
          short_d = (remaining_q != '0);
          state_d = S_DONE;
        end
      end
      S_EJECT: begin
        // abort is deliberately not sampled here so a pulse always completes
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort_w) begin
          owed_d  = remaining_q;
          short_d = (remaining_q != '0);
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      owed_q      <= '0;
      short_q     <= 1'b0;
      stock1_q    <= STOCK_W'(STOCK1_INIT);
      stock2_q    <= STOCK_W'(STOCK2_INIT);
      coin2_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      owed_q      <= owed_d;
      short_q     <= short_d;
      stock1_q    <= stock1_d;
      stock2_q    <= stock2_d;
      coin2_q     <= coin2_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ejects decode straight from state so an asynchronous reset drops them at once
  assign eject2    = (state_q == S_EJECT) &&  coin2_q;
  assign eject1    = (state_q == S_EJECT) && !coin2_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign short     = short_q;
  assign owed      = owed_q;
  assign stock1    = stock1_q;
  assign stock2    = stock2_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_amt;
  logic       req_ready;
  logic       load_stock;
  logic [3:0] load1, load2;
  logic       eject1, eject2, busy, done, short;
  logic [2:0] owed;
  logic [3:0] stock1, stock2;
`ifdef DISPENSE_ABORT_EN
  logic       abort;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // per-cycle traces, bit n = cycle n after the accept edge
  logic [63:0] e1_tr, e2_tr, done_tr, busy_tr;
  logic        both_hi, ready_end;
  logic [2:0]  owed_c1, done_owed;
  logic        done_short, done_seen;

  change_dispenser #(
    .AMT_W(3), .STOCK_W(4), .PULSE_CYC(2), .GAP_CYC(1),
    .STOCK1_INIT(8), .STOCK2_INIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .load_stock(load_stock), .load1(load1), .load2(load2),
    .eject1(eject1), .eject2(eject2), .busy(busy), .done(done),
    .short(short), .owed(owed), .stock1(stock1), .stock2(stock2)
`ifdef DISPENSE_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of cycle ncyc.
  task automatic run_req(input logic [2:0] amt, input int unsigned ncyc);
    req_valid = 1'b1;
    req_amt   = amt;
    e1_tr = '0; e2_tr = '0; done_tr = '0; busy_tr = '0;
    both_hi = 1'b0; done_owed = '0; done_short = 1'b0;
    @(negedge clk);
    req_valid  = 1'b0;
    load_stock = 1'b0;
    owed_c1    = owed;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      e1_tr[c]   = eject1;
      e2_tr[c]   = eject2;
      done_tr[c] = done;
      busy_tr[c] = busy;
      both_hi    = both_hi | (eject1 & eject2);
      if (done) begin
        done_owed  = owed;
        done_short = short;
      end
      if (c < ncyc) @(negedge clk);
    end
    ready_end = req_ready;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_amt = '0;
    load_stock = 1'b0; load1 = '0; load2 = '0;
`ifdef DISPENSE_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    chk("rst_ready_low", req_ready, 0);
    chk("rst_stock1", stock1, 8);
    chk("rst_stock2", stock2, 8);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ejects", {eject1, eject2}, 0);
    chk("rst_owed_short", {owed, short}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    @(negedge clk);

    // 1: 3 units from 8/8 -> one 2-coin, one 1-coin, done at cycle 10
    run_req(3'd3, 11);
    chk("t1_eject2", e2_tr, 64'h0C);
    chk("t1_eject1", e1_tr, 64'hC0);
    chk("t1_done", done_tr, 64'h400);
    chk("t1_busy", busy_tr, 64'h7FE);
    chk("t1_both", both_hi, 0);
    chk("t1_short_owed", {done_short, done_owed}, 0);
    chk("t1_stocks", {stock2, stock1}, 8'h77);
    chk("t1_ready", ready_end, 1);

    // 2: load 8/0 on the accept edge, 4 units -> four 1-coins, done at cycle 18
    load_stock = 1'b1; load1 = 4'd8; load2 = 4'd0;
    run_req(3'd4, 19);
    chk("t2_eject1", e1_tr, 64'hCCCC);
    chk("t2_eject2", e2_tr, 64'h0);
    chk("t2_done", done_tr, 64'h40000);
    chk("t2_short", done_short, 0);
    chk("t2_stocks", {stock2, stock1}, 8'h04);

    // 3: load 1/1, 5 units -> 2-coin, 1-coin, short by 2
    load_stock = 1'b1; load1 = 4'd1; load2 = 4'd1;
    run_req(3'd5, 11);
    chk("t3_eject2", e2_tr, 64'h0C);
    chk("t3_eject1", e1_tr, 64'hC0);
    chk("t3_done", done_tr, 64'h400);
    chk("t3_short_owed", {done_short, done_owed}, {1'b1, 3'd2});
    chk("t3_owed_hold", {short, owed}, {1'b1, 3'd2});
    chk("t3_stocks", {stock2, stock1}, 8'h00);

    // 4: zero amount -> done at cycle 2, owed cleared on accept, ready at 3
    run_req(3'd0, 3);
    chk("t4_owed_cleared", owed_c1, 0);
    chk("t4_ejects", e1_tr | e2_tr, 0);
    chk("t4_done", done_tr, 64'h4);
    chk("t4_short_owed", {done_short, done_owed}, 0);
    chk("t4_ready", ready_end, 1);

    // 5: reload 8/8, load ignored while busy, reset during the 2nd 2-coin pulse
    load_stock = 1'b1; load1 = 4'd8; load2 = 4'd8;
    @(negedge clk);
    load_stock = 1'b0;
    chk("t5_loaded", {stock2, stock1}, 8'h88);
    req_valid = 1'b1; req_amt = 3'd4;
    @(negedge clk);                      // cycle 1
    req_valid = 1'b0;
    load_stock = 1'b1; load1 = 4'd3; load2 = 4'd3;
    @(negedge clk);                      // cycle 2
    load_stock = 1'b0;
    chk("t5_busy_load_ignored", {stock2, stock1}, 8'h78);
    chk("t5_first_pulse", eject2, 1);
    repeat (4) @(negedge clk);           // cycle 6
    chk("t5_second_pulse", eject2, 1);
    chk("t5_stock2_mid", stock2, 6);
    rst = 1'b1;
    #1;
    chk("t5_rst_eject2", eject2, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", req_ready, 1);
    chk("t5_stocks_init", {stock2, stock1}, 8'h88);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      done_seen = done_seen | done | eject1 | eject2;
    end
    chk("t5_no_done", done_seen, 0);

`ifdef DISPENSE_ABORT_EN
    // 6: 6 units, abort held from the first pulse into the first GAP
    req_valid = 1'b1; req_amt = 3'd6;
    @(negedge clk);                      // cycle 1
    req_valid = 1'b0;
    @(negedge clk);                      // cycle 2
    abort = 1'b1;
    chk("t6_pulse_c2", eject2, 1);
    @(negedge clk);                      // cycle 3
    chk("t6_pulse_not_cut", eject2, 1);
    @(negedge clk);                      // cycle 4 (GAP)
    chk("t6_gap", {eject1, eject2, done}, 0);
    @(negedge clk);                      // cycle 5
    abort = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_short_owed", {short, owed}, {1'b1, 3'd4});
    chk("t6_stock2", stock2, 7);
    @(negedge clk);
    chk("t6_ready", req_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
